id_ex_pipeline_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core; sits directly downstream of the main control decoder and register file read.
- Captures the decoded control bundle and the ID-stage operands each cycle and presents them to the EX stage.
- Supports hold (stall), bubble insertion (flush) and a valid tag; optional performance counters.

---
 rtl/id_ex_pipeline_reg.sv | 140 ++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded control and operands for the EX stage, with stall/flush.
// Optional saturating performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [1:0]            id_jump,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_pc_plus_4,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [3:0]            id_funct,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [4:0]            id_rd,
    output logic                  ex_valid,
    output logic [1:0]            ex_jump,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_pc_plus_4,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [3:0]            ex_funct,
    output logic [4:0]            ex_rs1,
    output logic [4:0]            ex_rs2,
    output logic [4:0]            ex_rd,
    output logic [CNT_WIDTH-1:0]  perf_bubbles,
    output logic [CNT_WIDTH-1:0]  perf_stalls
);

    // Pipeline register: flush squashes (even a stalled slot), stall holds, otherwise load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_jump       <= 2'b00;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_pc         <= {DATA_WIDTH{1'b0}};
            ex_pc_plus_4  <= {DATA_WIDTH{1'b0}};
            ex_rs1_data   <= {DATA_WIDTH{1'b0}};
            ex_rs2_data   <= {DATA_WIDTH{1'b0}};
            ex_imm        <= {DATA_WIDTH{1'b0}};
            ex_funct      <= 4'd0;
            ex_rs1        <= 5'd0;
            ex_rs2        <= 5'd0;
            ex_rd         <= 5'd0;
        end else if (flush) begin
            // Data fields are left untouched; only side-effecting controls and rd are cleared.
            ex_valid      <= 1'b0;
            ex_jump       <= 2'b00;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_rd         <= 5'd0;
        end else if (stall) begin
            ex_valid      <= ex_valid;
        end else begin
            ex_valid      <= id_valid;
            ex_jump       <= id_jump;
            ex_branch     <= id_branch;
            ex_mem_read   <= id_mem_read;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_op     <= id_alu_op;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_reg_write  <= id_reg_write;
            ex_pc         <= id_pc;
            ex_pc_plus_4  <= id_pc_plus_4;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_funct      <= id_funct;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic bubble_evt_s;
    logic stall_evt_s;

    assign bubble_evt_s = flush | (~stall & ~id_valid);
    assign stall_evt_s  = stall & ~flush;

    // Saturating event counters; they stop at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bubbles <= {CNT_WIDTH{1'b0}};
            perf_stalls  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (bubble_evt_s && (perf_bubbles != CNT_MAX)) begin
                perf_bubbles <= perf_bubbles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                perf_bubbles <= perf_bubbles;
            end
            if (stall_evt_s && (perf_stalls != CNT_MAX)) begin
                perf_stalls <= perf_stalls + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                perf_stalls <= perf_stalls;
            end
        end
    end
`else
    assign perf_bubbles = {CNT_WIDTH{1'b0}};
    assign perf_stalls  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a driver pushes model expectations, a monitor pops and compares.
// Counter expectations follow ID_EX_PERF_CNT_EN; counters are instantiated 4 bits wide to exercise saturation.
module tb_id_ex_pipeline_reg;
    localparam int DW = 64;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic          rst, stall, flush, valid;
        logic [1:0]    jump, aop;
        logic          branch, mr, m2r, mw, asrc, rw;
        logic [DW-1:0] pc, pc4, r1d, r2d, imm;
        logic [3:0]    funct;
        logic [4:0]    rs1, rs2, rd;
    } in_t;

    typedef struct {
        in_t f;      // architectural view of the EX slot
        bit  dknown; // data fields defined (not after a flush)
        int  bub, stl;
    } exp_t;

    logic clk = 1'b0;
    logic reset, stall, flush, id_valid;
    logic [1:0] id_jump, id_alu_op;
    logic id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
    logic [DW-1:0] id_pc, id_pc_plus_4, id_rs1_data, id_rs2_data, id_imm;
    logic [3:0] id_funct;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic ex_valid;
    logic [1:0] ex_jump, ex_alu_op;
    logic ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [DW-1:0] ex_pc, ex_pc_plus_4, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0] ex_funct;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [CW-1:0] perf_bubbles, perf_stalls;

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    exp_t model;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_jump(id_jump), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_pc(id_pc),
        .id_pc_plus_4(id_pc_plus_4), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_funct(id_funct), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_funct(ex_funct), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t zero_in();
        in_t z;
        z = '{default: '0};
        return z;
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r = zero_in();
        r.valid = 1'($urandom_range(0, 3) != 0);
        r.pc = {$urandom, $urandom}; r.pc4 = {$urandom, $urandom};
        r.r1d = {$urandom, $urandom}; r.r2d = {$urandom, $urandom}; r.imm = {$urandom, $urandom};
        r.funct = 4'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
        if (r.valid) begin
            r.jump = 2'($urandom); r.aop = 2'($urandom); r.branch = 1'($urandom);
            r.mr = 1'($urandom); r.m2r = 1'($urandom); r.mw = 1'($urandom);
            r.asrc = 1'($urandom); r.rw = 1'($urandom);
        end
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic apply(input in_t i);
        reset = i.rst; stall = i.stall; flush = i.flush; id_valid = i.valid;
        id_jump = i.jump; id_branch = i.branch; id_mem_read = i.mr; id_mem_to_reg = i.m2r;
        id_alu_op = i.aop; id_mem_write = i.mw; id_alu_src = i.asrc; id_reg_write = i.rw;
        id_pc = i.pc; id_pc_plus_4 = i.pc4; id_rs1_data = i.r1d; id_rs2_data = i.r2d;
        id_imm = i.imm; id_funct = i.funct; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    endtask

    // Reference: reset empties the slot, a flush makes a harmless bubble, a stall freezes, else copy ID.
    task automatic cyc(input in_t i);
        @(negedge clk);
        apply(i);
        @(posedge clk);
        if (i.rst) begin
            model.f = zero_in(); model.dknown = 1'b1; model.bub = 0; model.stl = 0;
        end else if (i.flush) begin
            model.f.valid = 1'b0; model.f.jump = 2'b00; model.f.branch = 1'b0; model.f.mr = 1'b0;
            model.f.m2r = 1'b0; model.f.aop = 2'b00; model.f.mw = 1'b0; model.f.asrc = 1'b0;
            model.f.rw = 1'b0; model.f.rd = 5'd0; model.dknown = 1'b0;
            model.bub = sat(model.bub);
        end else if (i.stall) begin
            model.stl = sat(model.stl);
        end else begin
            model.f = i; model.dknown = 1'b1;
            if (!i.valid) model.bub = sat(model.bub);
        end
        q.push_back(model);
    endtask

    // Monitor: one registered output set per edge, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ex_valid", 64'(ex_valid), 64'(e.f.valid));
                chk("ex_jump", 64'(ex_jump), 64'(e.f.jump));
                chk("ex_branch", 64'(ex_branch), 64'(e.f.branch));
                chk("ex_mem_read", 64'(ex_mem_read), 64'(e.f.mr));
                chk("ex_mem_to_reg", 64'(ex_mem_to_reg), 64'(e.f.m2r));
                chk("ex_alu_op", 64'(ex_alu_op), 64'(e.f.aop));
                chk("ex_mem_write", 64'(ex_mem_write), 64'(e.f.mw));
                chk("ex_alu_src", 64'(ex_alu_src), 64'(e.f.asrc));
                chk("ex_reg_write", 64'(ex_reg_write), 64'(e.f.rw));
                chk("ex_rd", 64'(ex_rd), 64'(e.f.rd));
                if (e.dknown) begin
                    chk("ex_pc", ex_pc, e.f.pc);
                    chk("ex_pc_plus_4", ex_pc_plus_4, e.f.pc4);
                    chk("ex_rs1_data", ex_rs1_data, e.f.r1d);
                    chk("ex_rs2_data", ex_rs2_data, e.f.r2d);
                    chk("ex_imm", ex_imm, e.f.imm);
                    chk("ex_funct", 64'(ex_funct), 64'(e.f.funct));
                    chk("ex_rs1", 64'(ex_rs1), 64'(e.f.rs1));
                    chk("ex_rs2", 64'(ex_rs2), 64'(e.f.rs2));
                end
`ifdef ID_EX_PERF_CNT_EN
                chk("perf_bubbles", 64'(perf_bubbles), 64'(e.bub));
                chk("perf_stalls", 64'(perf_stalls), 64'(e.stl));
`else
                chk("perf_bubbles", 64'(perf_bubbles), 64'd0);
                chk("perf_stalls", 64'(perf_stalls), 64'd0);
`endif
            end
        end
    end

    initial begin
        in_t i;
        int budget;
        model.f = zero_in(); model.dknown = 1'b0; model.bub = 0; model.stl = 0;
        apply(zero_in());

        // Reset with every ID field at ones.
        i = '{default: '1}; i.stall = 1'b0; i.flush = 1'b0;
        cyc(i); cyc(i);
        i = zero_in(); i.valid = 1'b1; i.pc = 64'h100; i.rw = 1'b1;
        cyc(i);

        // Stall hold: rd=5/alu_op=10 held through three stalls while ID shows rd=7.
        i = zero_in(); i.rst = 1'b1; cyc(i);
        i = zero_in(); i.valid = 1'b1; i.rd = 5'd5; i.aop = 2'b10; cyc(i);
        i.rd = 5'd7; i.aop = 2'b01; i.stall = 1'b1;
        repeat (3) cyc(i);
        i.stall = 1'b0; cyc(i);

        // Flush squashes a store.
        i = zero_in(); i.rst = 1'b1; cyc(i);
        i = zero_in(); i.valid = 1'b1; i.mw = 1'b1; i.jump = 2'b01; i.branch = 1'b1; cyc(i);
        i.flush = 1'b1; cyc(i);

        // Flush and stall together give a bubble, not a hold.
        i = zero_in(); i.valid = 1'b1; i.rw = 1'b1; i.rd = 5'd9; i.mr = 1'b1; cyc(i);
        i.stall = 1'b1; i.flush = 1'b1; cyc(i);

        // JAL pass-through.
        i = zero_in(); i.valid = 1'b1; i.jump = 2'b11; i.pc4 = 64'h204; i.rd = 5'd1; i.rw = 1'b1;
        cyc(i);

        // Reset asserted mid-stall takes effect before the next edge.
        @(negedge clk);
        i.stall = 1'b1; i.rst = 1'b1; apply(i);
        #1;
        chk("async_reset_valid", 64'(ex_valid), 64'd0);
        chk("async_reset_jump", 64'(ex_jump), 64'd0);
        chk("async_reset_rd", 64'(ex_rd), 64'd0);
        cyc(i);

        // Saturation: 20 stall cycles.
        i = zero_in(); i.stall = 1'b1;
        repeat (20) cyc(i);

        // Randomized traffic with occasional resets.
        repeat (400) begin
            i = rand_in();
            i.stall = 1'($urandom_range(0, 3) == 0);
            i.flush = 1'($urandom_range(0, 7) == 0);
            i.rst = 1'($urandom_range(0, 63) == 0);
            cyc(i);
        end

        budget = 10;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
